seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have one clock, clk; reset rst is asynchronous and active-high.
REQ-002 SHALL have parameter WIDTH, default 16, datapath width (>=4, power of two).
REQ-003 SHALL have parameter LD_W, default 7, load-constant width (<=WIDTH).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 in_valid  in  1  operation offered.
REQ-007 in_ready  out  1  operation accepted when in_valid&&in_ready at clk edge.
REQ-008 op_c  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 MOVN, 7 MOV, 8 SHR, 9 SHL, A ROR, B CMP, C-F NOP.
REQ-009 cond  in  2  condition: 00 always, 01 Z=1, 10 Z=0, 11 N=1.
REQ-010 reg1, reg2  in  WIDTH  operands.
REQ-011 ld_sh  in  LD_W  MOVN constant; low log2(WIDTH) bits are the shift amount.
REQ-012 out_valid  out  1  result available; held until out_valid&&out_ready.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  WIDTH  result.
REQ-015 out_we  out  1  1 = destination must be written with out_data.
REQ-016 flag  out  4  registered flags {N,Z,C,V} (bits 3..0).

Function
REQ-017 FSM states IDLE, MUL_BUSY, DONE; in_ready = (IDLE) or (DONE and out_ready).
REQ-018 Accept in IDLE/DONE: non-MUL -> DONE next edge (latency 1); MUL with cond true -> MUL_BUSY.
REQ-019 MUL_BUSY lasts exactly WIDTH cycles (iterative shift-add), then DONE; out_valid exactly WIDTH+1 cycles after accept; in_ready=0 throughout.
REQ-020 DONE: out_valid=1; out_data/out_we/flag stable until handshake; handshake without new accept -> IDLE.
REQ-021 Condition evaluated at accept against current flag register; all earlier ops have retired, so no hazard.
REQ-022 Condition false or NOP: result issued with out_we=0, out_data=0, flags unchanged, latency 1 (MUL included).
REQ-023 ADD/SUB/MUL/CMP update flags when entering DONE; all other ops preserve flags.
REQ-024 ADD: WIDTH-bit sum; C = carry out; V = signed overflow.
REQ-025 SUB/CMP: reg1-reg2; C = 1 when reg1>=reg2 unsigned (no borrow); V = signed overflow; CMP out_we=0, out_data=0.
REQ-026 MUL: unsigned; out_data = low WIDTH bits; C=V=1 iff high WIDTH bits nonzero.
REQ-027 N = result MSB, Z = (result==0) for every flag-updating op (CMP uses difference).
REQ-028 MOVN: zero-extend ld_sh to WIDTH; MOV: reg1.
REQ-029 SHR logical, SHL, ROR by shift amount 0..WIDTH-1; amount 0 passes reg1 unchanged.
REQ-030 Back-to-back: DONE with handshake and new in_valid accepts in the same edge; sustained 1 op/cycle for non-MUL.

Reset
REQ-031 rst asserted, any state incl. mid-MUL: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_we=0, flag=0, multiplier registers cleared; in-flight op discarded.
REQ-032 First accept permitted on first clk edge after rst deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold opcode and condition constants, flag bit indices and the FSM state enum.
REQ-034 Sub-module alu_mul_iter (start, busy, done, WIDTH-parameterised 2*WIDTH product) SHALL implement the multiplier.

Verification (WIDTH=16)
REQ-035 ADD 0x7FFF+0x0001, cond 00 -> out_data 0x8000, out_we 1, flag 1001, out_valid 1 cycle after accept.
REQ-036 SUB 5-5 -> 0x0000, flag 0110; then MOVN ld_sh 0x7F cond 01 -> 0x007F out_we 1; cond 10 -> out_we 0, flag unchanged.
REQ-037 MUL 0x0100*0x0100 -> out_data 0x0000, flag 0111, out_valid exactly 17 cycles after accept, in_ready 0 for 16 cycles.
REQ-038 ROR 0x0001 by 1 -> 0x8000; SHL 0x0001 by 15 -> 0x8000; SHR 0x8000 by 0 -> 0x8000; flags unchanged.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_data/flag stable, in_ready 0; release -> one handshake only.
REQ-040 rst pulsed at MUL_BUSY cycle 8 -> out_valid 0, flag 0000, in_ready 1 immediately; next ADD 2+3 -> 0x0005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: opcode and condition-code constants, flag bit positions, the FSM state
// type, and a helper function that evaluates a condition code against the flags.
package alu_pkg;

    // Opcodes (op_c). Values 0xC..0xF are NOPs.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOVN = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;

    // Condition codes (cond).
    localparam logic [1:0] CC_AL = 2'b00;  // always
    localparam logic [1:0] CC_Z  = 2'b01;  // Z set
    localparam logic [1:0] CC_NZ = 2'b10;  // Z clear
    localparam logic [1:0] CC_N  = 2'b11;  // N set

    // Bit positions inside the {N,Z,C,V} flag register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    function automatic logic cond_met(input logic [1:0] cc, input logic [3:0] flags);
        case (cc)
            CC_Z:    return flags[FLAG_Z];
            CC_NZ:   return !flags[FLAG_Z];
            CC_N:    return flags[FLAG_N];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst   clock, async active-high reset (clears all state)
//   start      1-cycle pulse: capture a, b and perform the first step
//   a, b       WIDTH-bit unsigned operands (sampled only on start)
//   busy       high while further steps remain
//   done       1-cycle pulse in the cycle after the final step; product valid then
//   product    2*WIDTH-bit result
// Timing: start on edge k -> steps on edges k..k+WIDTH-1 -> done high in cycle k+WIDTH.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               done_q;

    // One shift-add step: the multiplier lives in the low half and is consumed
    // LSB first; the partial sum grows in the high half and shifts down.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                mcand  <= a;
                prod   <= step({{WIDTH{1'b0}}, b}, a);
                cnt    <= CNT_W'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                prod <= step(prod, mcand);
                cnt  <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes, condition codes and an iterative multiplier.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   operation offered / accepted (transfer when both high at clk edge)
//   op_c, cond            opcode and condition code
//   reg1, reg2, ld_sh     operands; ld_sh is the MOVN constant, its low bits the shift amount
//   out_valid / out_ready result offered / consumed (transfer when both high at clk edge)
//   out_data, out_we      result and destination write enable
//   flag                  registered {N,Z,C,V}
// Handshake: a side transfers only on a clock edge with valid and ready both high;
// once out_valid rises, out_data/out_we/flag hold until that transfer.
// Non-MUL ops (and MUL with a false condition) complete in 1 cycle; MUL spends
// WIDTH cycles in MUL_BUSY.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LD_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_c,
    input  logic [1:0]       cond,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [LD_W-1:0]  ld_sh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_we,
    output logic [3:0]       flag
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    state_t             state;
    logic               accept;
    logic               take;
    logic               mul_go;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   movn_val;
    logic [SH_W-1:0]    sh;
    logic [2*WIDTH-1:0] rot2;
    logic [WIDTH-1:0]   val;
    logic [WIDTH-1:0]   res;
    logic               res_we;
    logic               upd;
    logic [3:0]         res_flag;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    // Every earlier op has retired by accept time, so the flag register is current.
    assign take      = cond_met(cond, flag);
    assign mul_go    = accept && take && (op_c == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_go),
        .a       (reg1),
        .b       (reg2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle result path; MUL with a true condition never uses it.
    always_comb begin
        sum      = {1'b0, reg1} + {1'b0, reg2};
        diff     = {1'b0, reg1} - {1'b0, reg2};
        movn_val = '0;
        movn_val[LD_W-1:0] = ld_sh;
        sh       = ld_sh[SH_W-1:0];
        // Rotating a doubled copy keeps amount 0 well defined.
        rot2     = {reg1, reg1} >> sh;
        val      = '0;
        res_we   = 1'b0;
        upd      = 1'b0;
        res_flag = flag;
        if (take) begin
            case (op_c)
                OP_ADD: begin
                    val    = sum[WIDTH-1:0];
                    res_we = 1'b1;
                    upd    = 1'b1;
                    res_flag[FLAG_C] = sum[WIDTH];
                    res_flag[FLAG_V] = (reg1[MSB] == reg2[MSB]) && (sum[MSB] != reg1[MSB]);
                end
                OP_SUB, OP_CMP: begin
                    val    = diff[WIDTH-1:0];
                    res_we = (op_c == OP_SUB);
                    upd    = 1'b1;
                    // Carry means "no borrow", i.e. reg1 >= reg2 unsigned.
                    res_flag[FLAG_C] = !diff[WIDTH];
                    res_flag[FLAG_V] = (reg1[MSB] != reg2[MSB]) && (diff[MSB] != reg1[MSB]);
                end
                OP_OR:   begin val = reg1 | reg2;         res_we = 1'b1; end
                OP_AND:  begin val = reg1 & reg2;         res_we = 1'b1; end
                OP_XOR:  begin val = reg1 ^ reg2;         res_we = 1'b1; end
                OP_MOVN: begin val = movn_val;            res_we = 1'b1; end
                OP_MOV:  begin val = reg1;                res_we = 1'b1; end
                OP_SHR:  begin val = reg1 >> sh;          res_we = 1'b1; end
                OP_SHL:  begin val = reg1 << sh;          res_we = 1'b1; end
                OP_ROR:  begin val = rot2[WIDTH-1:0];     res_we = 1'b1; end
                default: begin val = '0;                  res_we = 1'b0; end
            endcase
        end
        if (upd) begin
            res_flag[FLAG_N] = val[MSB];
            res_flag[FLAG_Z] = (val == '0);
        end
        // Non-writing results (CMP, NOP, false condition) present zero data.
        res = res_we ? val : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            out_data <= '0;
            out_we   <= 1'b0;
            flag     <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (mul_go) begin
                            state <= ST_MUL_BUSY;
                        end else begin
                            state    <= ST_DONE;
                            out_data <= res;
                            out_we   <= res_we;
                            flag     <= res_flag;
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done && !mul_busy) begin
                        state    <= ST_DONE;
                        out_data <= mul_prod[WIDTH-1:0];
                        out_we   <= 1'b1;
                        flag     <= {mul_prod[MSB],
                                     (mul_prod[WIDTH-1:0] == '0),
                                     (mul_prod[2*WIDTH-1:WIDTH] != '0),
                                     (mul_prod[2*WIDTH-1:WIDTH] != '0)};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16). The driver pushes each expected result
// {we, flag, data} into exp_q as it offers an operation; the monitor pops and
// compares on every output handshake.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int LW = 7;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_c;
    logic [1:0]    cond;
    logic [W-1:0]  reg1;
    logic [W-1:0]  reg2;
    logic [LW-1:0] ld_sh;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_we;
    logic [3:0]    flag;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    logic [W+4:0] exp_q[$];
    logic [W+4:0] mon_e;

    seq_alu #(.WIDTH(W), .LD_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_c      (op_c),
        .cond      (cond),
        .reg1      (reg1),
        .reg2      (reg2),
        .ld_sh     (ld_sh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_we    (out_we),
        .flag      (flag)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [3:0] op, input logic [1:0] cc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [LW-1:0] ld, input logic push,
                        input logic [W-1:0] ed, input logic ewe, input logic [3:0] ef);
        int n;
        in_valid = 1'b1;
        op_c     = op;
        cond     = cc;
        reg1     = a;
        reg2     = b;
        ld_sh    = ld;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back({ewe, ef, ed});
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got data=0x%0h we=%0b flag=%b with nothing expected",
                         out_data, out_we, flag);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_data", {16'd0, out_data}, {16'd0, mon_e[W-1:0]});
                check("result_we",   {31'd0, out_we},   {31'd0, mon_e[W+4]});
                check("result_flag", {28'd0, flag},     {28'd0, mon_e[W+3:W]});
            end
        end
    end

    // ---------------- directed sequence ----------------
    int lat;
    int busy_rdy;
    int hs0;
    int stray;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_c      = 4'h0;
        cond      = CC_AL;
        reg1      = '0;
        reg2      = '0;
        ld_sh     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {16'd0, out_data},  32'd0);
        check("rst_out_we",    {31'd0, out_we},    32'd0);
        check("rst_flag",      {28'd0, flag},      32'd0);
        rst = 1'b0;

        // Arithmetic and conditional moves, issued back to back.
        send(OP_ADD,  CC_AL, 16'h7FFF, 16'h0001, 7'h00, 1'b1, 16'h8000, 1'b1, 4'b1001);
        check("add_latency", {31'd0, out_valid}, 32'd1);
        send(OP_SUB,  CC_AL, 16'h0005, 16'h0005, 7'h00, 1'b1, 16'h0000, 1'b1, 4'b0110);
        send(OP_MOVN, CC_Z,  16'h0000, 16'h0000, 7'h7F, 1'b1, 16'h007F, 1'b1, 4'b0110);
        send(OP_MOVN, CC_NZ, 16'h0000, 16'h0000, 7'h7F, 1'b1, 16'h0000, 1'b0, 4'b0110);

        // Multiply: latency and in_ready during the busy window.
        send(OP_MUL,  CC_AL, 16'h0100, 16'h0100, 7'h00, 1'b1, 16'h0000, 1'b1, 4'b0111);
        lat = 1;
        busy_rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy++;
            @(negedge clk);
            lat++;
        end
        check("mul_latency",      lat,      32'd17);
        check("mul_busy_in_ready", busy_rdy, 32'd0);

        // Shifts and logic; these keep the flags.
        send(OP_ROR,  CC_AL, 16'h0001, 16'h0000, 7'd1,  1'b1, 16'h8000, 1'b1, 4'b0111);
        send(OP_SHL,  CC_AL, 16'h0001, 16'h0000, 7'd15, 1'b1, 16'h8000, 1'b1, 4'b0111);
        send(OP_SHR,  CC_AL, 16'h8000, 16'h0000, 7'd0,  1'b1, 16'h8000, 1'b1, 4'b0111);
        send(OP_CMP,  CC_AL, 16'h0003, 16'h0005, 7'd0,  1'b1, 16'h0000, 1'b0, 4'b1000);
        send(4'hC,    CC_AL, 16'h1234, 16'h5678, 7'd0,  1'b1, 16'h0000, 1'b0, 4'b1000);
        send(OP_OR,   CC_N,  16'h00F0, 16'h0F00, 7'd0,  1'b1, 16'h0FF0, 1'b1, 4'b1000);
        send(OP_AND,  CC_AL, 16'hF0F0, 16'hFF00, 7'd0,  1'b1, 16'hF000, 1'b1, 4'b1000);
        send(OP_XOR,  CC_AL, 16'hAAAA, 16'hFFFF, 7'd0,  1'b1, 16'h5555, 1'b1, 4'b1000);
        send(OP_MOV,  CC_AL, 16'h1234, 16'h0000, 7'd0,  1'b1, 16'h1234, 1'b1, 4'b1000);
        // MUL with a false condition completes in one cycle with no write.
        send(OP_MUL,  CC_Z,  16'h0003, 16'h0004, 7'd0,  1'b1, 16'h0000, 1'b0, 4'b1000);
        check("mul_false_latency", {31'd0, out_valid}, 32'd1);
        send(OP_ADD,  CC_AL, 16'hFFFF, 16'h0001, 7'd0,  1'b1, 16'h0000, 1'b1, 4'b0110);
        @(negedge clk);

        // Output stall: result must hold, no accept, exactly one handshake on release.
        out_ready = 1'b0;
        send(OP_ADD,  CC_AL, 16'h0002, 16'h0002, 7'd0,  1'b1, 16'h0004, 1'b1, 4'b0000);
        hs0 = hs_count;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",    {31'd0, out_valid}, 32'd1);
            check("stall_data",     {16'd0, out_data},  32'h0004);
            check("stall_flag",     {28'd0, flag},      32'd0);
            check("stall_in_ready", {31'd0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_idle", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("stall_one_handshake", hs_count - hs0, 32'd1);

        // Reset in the middle of a multiply.
        send(OP_MUL,  CC_AL, 16'h0003, 16'h0004, 7'd0,  1'b0, 16'h0000, 1'b0, 4'b0000);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midmul_rst_valid",    {31'd0, out_valid}, 32'd0);
        check("midmul_rst_flag",     {28'd0, flag},      32'd0);
        check("midmul_rst_in_ready", {31'd0, in_ready},  32'd1);
        check("midmul_rst_data",     {16'd0, out_data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("midmul_no_stray", stray, 32'd0);
        send(OP_ADD,  CC_AL, 16'h0002, 16'h0003, 7'd0,  1'b1, 16'h0005, 1'b1, 4'b0000);
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
